// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM generator with Avalon-MM registers, clamping and slew limiting.
// Define SERVO_STAGGER_EN to spread channel pulse starts evenly across the frame.
module servo_pwm_multi #(
    parameter int NUM_CH    = 2,
    parameter int CLK_HZ    = 50000000,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int CENTER_US = 1500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [NUM_CH-1:0]     servo_out,
    output logic [16*NUM_CH-1:0]  pos_export,
    output logic                  frame_irq
);
    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [15:0] US_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0] MIN_W = 16'(MIN_US);
    localparam logic [15:0] MAX_W = 16'(MAX_US);
    localparam logic [15:0] CTR_W = 16'(CENTER_US);

    logic [PW-1:0]        pre;
    logic [15:0]          us_count, frame_cnt, step, wr_clamped;
    logic [NUM_CH-1:0]    ctrl, run, ctrl_nx, run_nx, busy, hit;
    logic [16*NUM_CH-1:0] tgt_bus;
    logic                 tick, frame_start;
    logic [31:0]          rd_mux;
    logic                 unused_bits;

    assign unused_bits = ^writedata[31:16];
    assign tick        = pre == PRE_LAST;
    assign frame_start = tick && us_count == US_LAST;
    assign wr_clamped  = writedata[15:0] < MIN_W ? MIN_W : writedata[15:0] > MAX_W ? MAX_W : writedata[15:0];
    assign ctrl_nx     = (write && address == 4'd0) ? writedata[NUM_CH-1:0] : ctrl;
    // Enables arm only at a frame start, but disables take effect at once.
    assign run_nx      = frame_start ? ctrl_nx : run & ctrl_nx;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [15:0] tgt, cur, up, dn, nxt, phase;
        assign up  = tgt - cur;
        assign dn  = cur - tgt;
        assign nxt = step == 16'd0 ? tgt :
                     tgt >= cur ? (up <= step ? tgt : cur + step) :
                                  (dn <= step ? tgt : cur - step);
`ifdef SERVO_STAGGER_EN
        localparam logic [15:0] OFF = 16'(k * (PERIOD_US / NUM_CH));
        assign phase = us_count >= OFF ? us_count - OFF : us_count + 16'(PERIOD_US) - OFF;
`else
        assign phase = us_count;
`endif
        assign hit[k]                 = phase < cur;
        assign busy[k]                = cur != tgt;
        assign tgt_bus[16*k +: 16]    = tgt;
        assign pos_export[16*k +: 16] = cur;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                tgt <= CTR_W;
                cur <= CTR_W;
            end else begin
                if (write && address == 4'(4 + k)) tgt <= wr_clamped;
                if (frame_start) cur <= nxt;
            end
        end
    end

    always_comb begin
        rd_mux = address == 4'd0 ? 32'(ctrl) :
                 address == 4'd1 ? {16'd0, step} :
                 address == 4'd2 ? 32'(busy) :
                 address == 4'd3 ? {16'd0, frame_cnt} : 32'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (address == 4'(4 + i)) rd_mux = {16'd0, tgt_bus[16*i +: 16]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre       <= '0;
            us_count  <= '0;
            frame_cnt <= '0;
            step      <= '0;
            ctrl      <= '0;
            run       <= '0;
            servo_out <= '0;
            frame_irq <= 1'b0;
            readdata  <= '0;
        end else begin
            pre       <= tick ? '0 : pre + 1'b1;
            if (tick) us_count <= us_count == US_LAST ? 16'd0 : us_count + 16'd1;
            frame_irq <= frame_start;
            if (frame_start) frame_cnt <= frame_cnt + 16'd1;
            if (write && address == 4'd1) step <= writedata[15:0];
            ctrl      <= ctrl_nx;
            run       <= run_nx;
            servo_out <= run_nx & hit;
            if (read) readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed scoreboard bench for servo_pwm_multi (2 channels, 200-clk frames).
module tb_servo_pwm_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  servo_out;
    logic [31:0] pos_export;
    logic        frame_irq;
    int          checks = 0;
    int          errors = 0;
    int          h0, h1, cnt;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH(2), .CLK_HZ(2000000), .PERIOD_US(100),
        .MIN_US(10), .MAX_US(50), .CENTER_US(30)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .servo_out(servo_out), .pos_export(pos_export), .frame_irq(frame_irq)
    );

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected nothing", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] e);
        push(t, e);
        pop_check(obs);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string t, input logic [31:0] e);
        push(t, e);
        read = 1'b1;
        address = a;
        @(negedge clk);
        read = 1'b0;
        pop_check(readdata);
    endtask

    task automatic wait_frame();
        @(negedge clk);
        for (int n = 0; n < 400 && !frame_irq; n++) @(negedge clk);
        chk("frame_start_seen", 32'(frame_irq), 1);
    endtask

    task automatic measure(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 200; i++) begin
            c0 += int'(servo_out[0]);
            c1 += int'(servo_out[1]);
            @(negedge clk);
        end
    endtask

    initial begin
        step(3);
        chk("rst_servo_out", 32'(servo_out), 0);
        chk("rst_frame_irq", 32'(frame_irq), 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_pos_export", pos_export, 32'h001e_001e);
        reset = 1'b0;

        // Enable both channels: nothing may appear before the first frame start
        wr(4'd0, 32'd3);
        chk("no_partial_first_pulse", 32'(servo_out), 0);
        rd(4'd0, "ctrl_readback", 3);
        rd(4'd3, "frame_cnt_initial", 0);
        rd(4'd12, "unmapped_read", 0);
        wait_frame();
        push("w0_center", 60);
        push("w1_center", 60);
        measure(h0, h1);
        pop_check(h0);
        pop_check(h1);
        chk("irq_period_200", 32'(frame_irq), 1);
        chk("pos_center", pos_export, 32'h001e_001e);

        // Clamping to MIN/MAX
        wr(4'd4, 32'd5);
        wr(4'd5, 32'd90);
        rd(4'd4, "tgt0_clamp_min", 10);
        rd(4'd5, "tgt1_clamp_max", 50);
        rd(4'd2, "status_both_pending", 3);
        rd(4'd6, "absent_channel_read", 0);
        wait_frame();
        chk("pos_clamped", pos_export, 32'h0032_000a);
        push("w0_clamped", 20);
        push("w1_clamped", 100);
        measure(h0, h1);
        pop_check(h0);
        pop_check(h1);

        // Slew limiting, STEP=4, 30 -> 42
        wr(4'd4, 32'd30);
        wr(4'd5, 32'd30);
        wait_frame();
        wr(4'd1, 32'd4);
        wr(4'd4, 32'd42);
        rd(4'd1, "step_readback", 4);
        rd(4'd2, "status_slew_start", 1);
        wait_frame();
        chk("slew_34", 32'(pos_export[15:0]), 34);
        rd(4'd2, "status_slew_34", 1);
        wait_frame();
        chk("slew_38", 32'(pos_export[15:0]), 38);
        rd(4'd2, "status_slew_38", 1);
        wait_frame();
        chk("slew_42", 32'(pos_export[15:0]), 42);
        rd(4'd2, "status_slew_done", 0);
        wr(4'd1, 32'd0);

        // Disable channel 1 mid-pulse at us 15, then re-enable mid-frame
        wait_frame();
        step(30);
        chk("ch1_high_us15", 32'(servo_out[1]), 1);
        wr(4'd0, 32'd1);
        chk("ch1_off_next_cycle", 32'(servo_out[1]), 0);
        chk("ch0_unaffected", 32'(servo_out[0]), 1);
        wr(4'd0, 32'd3);
        push("ch1_no_midframe_pulse", 0);
        cnt = 0;
        for (int n = 0; n < 400 && !frame_irq; n++) begin
            cnt += int'(servo_out[1]);
            @(negedge clk);
        end
        pop_check(cnt);
        chk("rearm_frame_start", 32'(frame_irq), 1);
        push("w0_42", 84);
        push("w1_rearmed", 60);
        measure(h0, h1);
        pop_check(h0);
        pop_check(h1);

        // TARGET_0 written in the exact frame-start cycle
        step(199);
        wr(4'd4, 32'd20);
        chk("irq_alignment", 32'(frame_irq), 1);
        chk("old_width_kept", 32'(pos_export[15:0]), 42);
        push("w0_old_width", 84);
        measure(h0, h1);
        pop_check(h0);
        chk("new_width_next_frame", 32'(pos_export[15:0]), 20);
        push("w0_new_width", 40);
        measure(h0, h1);
        pop_check(h0);

        // Reset at us 10 while both outputs are high
        rd(4'd3, "frame_count_14", 14);
        step(19);
        chk("ch0_high_us10", 32'(servo_out), 3);
        reset = 1'b1;
        #1;
        chk("async_reset_drop", 32'(servo_out), 0);
        chk("async_reset_pos", pos_export, 32'h001e_001e);
        step(2);
        reset = 1'b0;
        rd(4'd4, "tgt0_after_reset", 30);
        rd(4'd3, "frame_after_reset", 0);
        rd(4'd0, "ctrl_after_reset", 0);
        rd(4'd1, "step_after_reset", 0);
        chk("out_low_after_reset", 32'(servo_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
